// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encodings for the AES-128 control unit.
// Imported by the main controller and by the encryption sequencer.
package aes_ctrl_pkg;

  localparam int DATA_W     = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int RND_W      = 4;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_LOAD    = 2'd1,
    M_PROCESS = 2'd2,
    M_SEND    = 2'd3
  } main_state_e;

  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_ADD   = 3'd1,
    E_KEY   = 3'd2,
    E_SUB   = 3'd3,
    E_SHIFT = 3'd4,
    E_MIX   = 3'd5,
    E_DONE  = 3'd6
  } encr_state_e;

endpackage

// File: rtl/aes_encr_fsm.sv
// Encryption step sequencer: walks the datapath through AddRoundKey, key expansion,
// SubBytes, ShiftRows and MixColumns, one strobe handshake per step; owns round_cnt.
module aes_encr_fsm #(
  parameter int NUM_ROUNDS = aes_ctrl_pkg::NUM_ROUNDS,
  parameter int RND_W      = aes_ctrl_pkg::RND_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clr_round,
  input  logic             i_key_addition,
  input  logic             i_round_key_get_ready,
  input  logic             i_byte_subs,
  input  logic             i_shift_rows,
  input  logic             i_mix_columns,
  output logic [RND_W-1:0] round_cnt,
  output logic             o_add,
  output logic             o_calc_round_key,
  output logic             o_substitute,
  output logic             o_shift_rows,
  output logic             o_mix_columns,
  output logic             done
);
  import aes_ctrl_pkg::*;

  encr_state_e      state_r;
  encr_state_e      state_next_s;
  logic [RND_W-1:0] round_cnt_r;
  logic             last_round_s;
  logic             round_inc_s;
  logic             o_add_r;
  logic             o_calc_round_key_r;
  logic             o_substitute_r;
  logic             o_shift_rows_r;
  logic             o_mix_columns_r;
  logic             done_r;

  assign last_round_s = (round_cnt_r == RND_W'(NUM_ROUNDS));

  // Next-state logic: each step waits for its own strobe, all other strobes are ignored
  always_comb begin
    state_next_s = state_r;
    round_inc_s  = 1'b0;
    case (state_r)
      E_IDLE: begin
        if (start) state_next_s = E_ADD;
        else       state_next_s = state_r;
      end
      E_ADD: begin
        if (i_key_addition) begin
          if (last_round_s) state_next_s = E_DONE;
          else              state_next_s = E_KEY;
        end else begin
          state_next_s = state_r;
        end
      end
      E_KEY: begin
        if (i_round_key_get_ready) begin
          state_next_s = E_SUB;
          round_inc_s  = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      E_SUB: begin
        if (i_byte_subs) state_next_s = E_SHIFT;
        else             state_next_s = state_r;
      end
      E_SHIFT: begin
        // The final round skips MixColumns
        if (i_shift_rows) begin
          if (last_round_s) state_next_s = E_ADD;
          else              state_next_s = E_MIX;
        end else begin
          state_next_s = state_r;
        end
      end
      E_MIX: begin
        if (i_mix_columns) state_next_s = E_ADD;
        else               state_next_s = state_r;
      end
      E_DONE:  state_next_s = E_IDLE;
      default: state_next_s = E_IDLE;
    endcase
  end

  // State register with request outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= E_IDLE;
      o_add_r            <= 1'b0;
      o_calc_round_key_r <= 1'b0;
      o_substitute_r     <= 1'b0;
      o_shift_rows_r     <= 1'b0;
      o_mix_columns_r    <= 1'b0;
      done_r             <= 1'b0;
    end else begin
      state_r            <= state_next_s;
      o_add_r            <= (state_next_s == E_ADD);
      o_calc_round_key_r <= (state_next_s == E_KEY);
      o_substitute_r     <= (state_next_s == E_SUB);
      o_shift_rows_r     <= (state_next_s == E_SHIFT);
      o_mix_columns_r    <= (state_next_s == E_MIX);
      done_r             <= (state_next_s == E_DONE);
    end
  end

  // Round counter: cleared when a new load begins, stepped on each round key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_cnt_r <= {RND_W{1'b0}};
    end else if (clr_round) begin
      round_cnt_r <= {RND_W{1'b0}};
    end else if (round_inc_s && !last_round_s) begin
      round_cnt_r <= round_cnt_r + RND_W'(1);
    end
  end

  assign round_cnt        = round_cnt_r;
  assign o_add            = o_add_r;
  assign o_calc_round_key = o_calc_round_key_r;
  assign o_substitute     = o_substitute_r;
  assign o_shift_rows     = o_shift_rows_r;
  assign o_mix_columns    = o_mix_columns_r;
  assign done             = done_r;

endmodule

// File: rtl/aes_ctrl_fsms.sv
// AES-128 control unit top: main load/process/send FSM plus the text and key registers,
// driving the encryption step sequencer.
module aes_ctrl_fsms #(
  parameter int DATA_W     = aes_ctrl_pkg::DATA_W,
  parameter int NUM_ROUNDS = aes_ctrl_pkg::NUM_ROUNDS,
  parameter int RND_W      = aes_ctrl_pkg::RND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              i_done,
  input  logic              i_data_received_text,
  input  logic              i_data_received_key,
  input  logic [DATA_W-1:0] data,
  input  logic              i_byte_subs,
  input  logic              i_shift_rows,
  input  logic              i_mix_columns,
  input  logic              i_key_addition,
  input  logic              i_round_key_get_ready,
  output logic [RND_W-1:0]  round_cnt,
  output logic              o_add,
  output logic              o_substitute,
  output logic              o_shift_rows,
  output logic              o_mix_columns,
  output logic              o_calc_round_key,
  output logic              o_load,
  output logic              o_send,
  output logic [DATA_W-1:0] cipher_text,
  output logic [DATA_W-1:0] prime_key
);
  import aes_ctrl_pkg::*;

  main_state_e       main_r;
  main_state_e       main_next_s;
  logic              text_flag_r;
  logic              key_flag_r;
  logic [DATA_W-1:0] cipher_text_r;
  logic [DATA_W-1:0] prime_key_r;
  logic              o_load_r;
  logic              o_send_r;
  logic              enter_load_s;
  logic              enc_start_s;
  logic              enc_done_s;

  // Main next-state logic; start is only honoured from idle
  always_comb begin
    main_next_s  = main_r;
    enter_load_s = 1'b0;
    enc_start_s  = 1'b0;
    case (main_r)
      M_IDLE: begin
        if (start) begin
          main_next_s  = M_LOAD;
          enter_load_s = 1'b1;
        end else begin
          main_next_s = main_r;
        end
      end
      M_LOAD: begin
        if (text_flag_r && key_flag_r) begin
          main_next_s = M_PROCESS;
          enc_start_s = 1'b1;
        end else begin
          main_next_s = main_r;
        end
      end
      M_PROCESS: begin
        if (enc_done_s) main_next_s = M_SEND;
        else            main_next_s = main_r;
      end
      M_SEND: begin
        if (i_done) main_next_s = M_IDLE;
        else        main_next_s = main_r;
      end
      default: main_next_s = M_IDLE;
    endcase
  end

  // Main state register with registered load/send requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_r   <= M_IDLE;
      o_load_r <= 1'b0;
      o_send_r <= 1'b0;
    end else begin
      main_r   <= main_next_s;
      o_load_r <= (main_next_s == M_LOAD);
      o_send_r <= (main_next_s == M_SEND);
    end
  end

  // Load capture; a simultaneous key strobe loses to the text strobe on the shared bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_flag_r   <= 1'b0;
      key_flag_r    <= 1'b0;
      cipher_text_r <= {DATA_W{1'b0}};
      prime_key_r   <= {DATA_W{1'b0}};
    end else if (enter_load_s) begin
      text_flag_r <= 1'b0;
      key_flag_r  <= 1'b0;
    end else if (main_r == M_LOAD) begin
      if (i_data_received_text) begin
        cipher_text_r <= data;
        text_flag_r   <= 1'b1;
      end else if (i_data_received_key) begin
        prime_key_r <= data;
        key_flag_r  <= 1'b1;
      end
    end
  end

  aes_encr_fsm #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) u_encr_fsm (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (enc_start_s),
    .clr_round             (enter_load_s),
    .i_key_addition        (i_key_addition),
    .i_round_key_get_ready (i_round_key_get_ready),
    .i_byte_subs           (i_byte_subs),
    .i_shift_rows          (i_shift_rows),
    .i_mix_columns         (i_mix_columns),
    .round_cnt             (round_cnt),
    .o_add                 (o_add),
    .o_calc_round_key      (o_calc_round_key),
    .o_substitute          (o_substitute),
    .o_shift_rows          (o_shift_rows),
    .o_mix_columns         (o_mix_columns),
    .done                  (enc_done_s)
  );

  assign cipher_text = cipher_text_r;
  assign prime_key   = prime_key_r;
  assign o_load      = o_load_r;
  assign o_send      = o_send_r;

endmodule

// File: tb/tb_aes_ctrl_fsms.sv
// Scoreboard bench for aes_ctrl_fsms: a driver acts as loader and datapath responder,
// a monitor checks every new request against the expected AES step sequence.
module tb_aes_ctrl_fsms;
  localparam int DW = 128;
  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset, start, i_done, i_data_received_text, i_data_received_key;
  logic [DW-1:0] data;
  logic          i_byte_subs, i_shift_rows, i_mix_columns, i_key_addition, i_round_key_get_ready;
  logic [RW-1:0] round_cnt;
  logic          o_add, o_substitute, o_shift_rows, o_mix_columns, o_calc_round_key, o_load, o_send;
  logic [DW-1:0] cipher_text, prime_key;
  logic [6:0]    req_vec;

  aes_ctrl_fsms dut (
    .clk(clk), .reset(reset), .start(start), .i_done(i_done),
    .i_data_received_text(i_data_received_text), .i_data_received_key(i_data_received_key),
    .data(data), .i_byte_subs(i_byte_subs), .i_shift_rows(i_shift_rows),
    .i_mix_columns(i_mix_columns), .i_key_addition(i_key_addition),
    .i_round_key_get_ready(i_round_key_get_ready), .round_cnt(round_cnt),
    .o_add(o_add), .o_substitute(o_substitute), .o_shift_rows(o_shift_rows),
    .o_mix_columns(o_mix_columns), .o_calc_round_key(o_calc_round_key),
    .o_load(o_load), .o_send(o_send), .cipher_text(cipher_text), .prime_key(prime_key)
  );

  always #5 clk = ~clk;

  // bit order: 0 add, 1 sub, 2 shift, 3 mix, 4 round key, 5 load, 6 send
  assign req_vec = {o_send, o_load, o_calc_round_key, o_mix_columns, o_shift_rows, o_substitute, o_add};

  localparam int R_ADD = 0, R_SUB = 1, R_SHIFT = 2, R_MIX = 3, R_KEY = 4, R_LOAD = 5, R_SEND = 6;

  typedef struct {
    int            req;
    int            rnd;
    bit            chk_data;
    logic [DW-1:0] text;
    logic [DW-1:0] key;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void push_exp(input int req, input int rnd, input bit chk,
                                   input logic [DW-1:0] t, input logic [DW-1:0] k);
    exp_t e;
    e.req = req; e.rnd = rnd; e.chk_data = chk; e.text = t; e.key = k;
    sb_q.push_back(e);
  endfunction

  // AES-128 schedule: initial AddRoundKey, rounds 1..9 with MixColumns, round 10 without
  function automatic void push_txn(input logic [DW-1:0] t, input logic [DW-1:0] k);
    push_exp(R_LOAD, 0, 1'b0, t, k);
    push_exp(R_ADD, 0, 1'b1, t, k);
    for (int r = 1; r <= NR; r++) begin
      push_exp(R_KEY, r - 1, 1'b0, t, k);
      push_exp(R_SUB, r, 1'b0, t, k);
      push_exp(R_SHIFT, r, 1'b0, t, k);
      if (r < NR) push_exp(R_MIX, r, 1'b0, t, k);
      push_exp(R_ADD, r, 1'b0, t, k);
    end
    push_exp(R_SEND, NR, 1'b1, t, k);
  endfunction

  // Monitor: every newly presented request is popped from the scoreboard and compared
  initial begin
    logic [6:0] prev;
    exp_t       e;
    prev = 7'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 7'd0;
      end else begin
        if (req_vec != prev && req_vec != 7'd0) begin
          checks++;
          if (!$onehot(req_vec)) begin
            failures++;
            $display("FAIL onehot req=%b required exactly one bit set", req_vec);
          end
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_req req=%b rnd=%0d required no request", req_vec, round_cnt);
          end else begin
            e = sb_q.pop_front();
            if (req_vec != (7'd1 << e.req) || round_cnt != RW'(e.rnd)) begin
              failures++;
              $display("FAIL req_seq req=%b rnd=%0d required req=%b rnd=%0d",
                       req_vec, round_cnt, 7'd1 << e.req, e.rnd);
            end
            if (e.chk_data) begin
              checks++;
              if (cipher_text != e.text || prime_key != e.key) begin
                failures++;
                $display("FAIL data_regs text=%h key=%h required text=%h key=%h",
                         cipher_text, prime_key, e.text, e.key);
              end
            end
          end
        end
        prev = req_vec;
      end
    end
  end

  // Strobe index: 0..4 datapath steps (same order as req bits), 5 text, 6 key, 7 i_done, 8 start
  task automatic set_strb(input int idx, input logic v);
    case (idx)
      0: i_key_addition = v;
      1: i_byte_subs = v;
      2: i_shift_rows = v;
      3: i_mix_columns = v;
      4: i_round_key_get_ready = v;
      5: begin i_data_received_text = v; if (v) data = rand128(); end
      6: begin i_data_received_key = v; if (v) data = rand128(); end
      7: i_done = v;
      8: start = v;
      default: ;
    endcase
  endtask

  task automatic pulse(input int idx);
    set_strb(idx, 1'b1);
    @(negedge clk);
    set_strb(idx, 1'b0);
  endtask

  task automatic recover();
    reset = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((req_vec & 7'b1011111) != 7'd0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // One encryption: load in the chosen order, answer requests with random stray strobes
  task automatic run_txn(input logic [DW-1:0] pt, input logic [DW-1:0] key,
                         input int variant, input int abort_rnd);
    bit ok;
    int idx, s;
    push_txn(pt, key);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (o_load !== 1'b1) begin
      failures++;
      $display("FAIL load_latency o_load=%b required 1", o_load);
    end
    case (variant)
      0: begin
        data = pt; i_data_received_text = 1'b1; @(negedge clk); i_data_received_text = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        data = key; i_data_received_key = 1'b1; @(negedge clk); i_data_received_key = 1'b0;
      end
      1: begin
        data = key; i_data_received_key = 1'b1; @(negedge clk); i_data_received_key = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        data = pt; i_data_received_text = 1'b1; @(negedge clk); i_data_received_text = 1'b0;
      end
      default: begin
        data = pt; i_data_received_text = 1'b1; i_data_received_key = 1'b1;
        @(negedge clk);
        i_data_received_text = 1'b0; i_data_received_key = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        data = key; i_data_received_key = 1'b1; @(negedge clk); i_data_received_key = 1'b0;
      end
    endcase
    for (int step = 0; step < 120; step++) begin
      wait_req(ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL req_timeout req=%b required a request within 40 cycles", req_vec);
        recover();
        return;
      end
      if (o_send) begin
        if ($urandom_range(0, 1) == 1) pulse(8);
        pulse(7);
        checks++;
        if (o_send !== 1'b0 || o_load !== 1'b0) begin
          failures++;
          $display("FAIL send_release send=%b load=%b required 0 0", o_send, o_load);
        end
        return;
      end
      idx = 0;
      for (int b = 0; b < 5; b++) if (req_vec[b]) idx = b;
      if (abort_rnd != 0 && o_substitute && round_cnt == RW'(abort_rnd)) begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_vec != 7'd0 || round_cnt != 4'd0 || cipher_text != '0 || prime_key != '0) begin
          failures++;
          $display("FAIL abort_clear req=%b rnd=%0d text=%h key=%h required all 0",
                   req_vec, round_cnt, cipher_text, prime_key);
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        s = $urandom_range(0, 8);
        if (s != idx) pulse(s);
        else @(negedge clk);
      end
      pulse(idx);
    end
    checks++; failures++;
    $display("FAIL step_budget no send after 120 responses");
    recover();
  endtask

  task automatic check_sb_empty();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_empty pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; i_done = 1'b0;
    i_data_received_text = 1'b0; i_data_received_key = 1'b0; data = '0;
    i_byte_subs = 1'b0; i_shift_rows = 1'b0; i_mix_columns = 1'b0;
    i_key_addition = 1'b0; i_round_key_get_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (req_vec != 7'd0 || round_cnt != 4'd0 || cipher_text != '0 || prime_key != '0) begin
      failures++;
      $display("FAIL reset_state req=%b rnd=%0d text=%h key=%h required all 0",
               req_vec, round_cnt, cipher_text, prime_key);
    end
    reset = 1'b0;
    @(negedge clk);
    run_txn(128'h54776F204F6E65204E696E652054776F, 128'h5468617473206D79204B756E67204675, 0, 0);
    check_sb_empty();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(rand128(), rand128(), k % 3, 0);
      check_sb_empty();
    end
    run_txn(rand128(), rand128(), 0, 5);
    run_txn(rand128(), rand128(), 2, 0);
    check_sb_empty();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
